rv_fifo: RTL

RV_FIFO -- requirements
Module: rv_fifo

---
 rtl/rv_pkg.sv | 18 +
 rtl/rv_fifo_mem.sv | 25 ++
 rtl/rv_fifo.sv | 77 +++++++
 3 files changed

// File: rtl/rv_pkg.sv
// Shared sizing helpers for the ready/valid FIFO: pointer and occupancy widths
// plus the DEPTH legality rule (power of two, at least 2).
package rv_pkg;

   function automatic int ptr_w(input int depth);
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction

   // One extra bit so a full FIFO (count == DEPTH) is distinct from an empty one.
   function automatic int cnt_w(input int depth);
      return $clog2(depth) + 1;
   endfunction

   function automatic bit depth_ok(input int depth);
      return (depth >= 2) && ((depth & (depth - 1)) == 0);
   endfunction

endpackage

// File: rtl/rv_fifo_mem.sv
// FIFO storage array: write lands on the rising edge, read is combinational.
// Contents are deliberately not reset; validity is tracked by the owner.
module rv_fifo_mem
   import rv_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int DEPTH      = 4
) (
   input  logic                      clk,
   input  logic                      we,
   input  logic [ptr_w(DEPTH)-1:0]   waddr,
   input  logic [DATA_WIDTH-1:0]     wdata,
   input  logic [ptr_w(DEPTH)-1:0]   raddr,
   output logic [DATA_WIDTH-1:0]     rdata
);

   logic [DATA_WIDTH-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/rv_fifo.sv
// Ready/valid FIFO, one-cycle push-to-output latency; wr_o/rv_o depend only on registered count.
// A full FIFO refuses pushes even while popping. Optional level_o under macro RV_FIFO_LEVEL_EN.
module rv_fifo
   import rv_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int DEPTH      = 4
) (
   input  logic                       clk,
   input  logic                       rstn,
   input  logic                       wv_i,
   output logic                       wr_o,
   input  logic [DATA_WIDTH-1:0]      wd_i,
   output logic                       rv_o,
   input  logic                       rr_i,
`ifdef RV_FIFO_LEVEL_EN
   output logic [cnt_w(DEPTH)-1:0]    level_o,
`endif
   output logic [DATA_WIDTH-1:0]      rd_o
);

   localparam int PW = ptr_w(DEPTH);
   localparam int CW = cnt_w(DEPTH);
   localparam logic [CW-1:0] FULL = CW'(DEPTH);

   if (!depth_ok(DEPTH)) begin : g_bad_depth
      $error("rv_fifo: DEPTH must be a power of two and at least 2");
   end

   logic [PW-1:0]         wptr;
   logic [PW-1:0]         rptr;
   logic [CW-1:0]         count;
   logic                  push;
   logic                  pop;
   logic [DATA_WIDTH-1:0] mem_rdata;

   assign rv_o = (count != '0);
   // Gated by rstn so the write side reads not-ready for the whole reset window.
   assign wr_o = rstn & (count != FULL);
   assign push = wv_i & wr_o;
   assign pop  = rv_o & rr_i;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         wptr  <= '0;
         rptr  <= '0;
         count <= '0;
      end else begin
         if (push) wptr <= wptr + 1'b1;
         if (pop)  rptr <= rptr + 1'b1;
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   rv_fifo_mem #(
      .DATA_WIDTH (DATA_WIDTH),
      .DEPTH      (DEPTH)
   ) u_mem (
      .clk   (clk),
      .we    (push),
      .waddr (wptr),
      .wdata (wd_i),
      .raddr (rptr),
      .rdata (mem_rdata)
   );

   assign rd_o = rv_o ? mem_rdata : '0;

`ifdef RV_FIFO_LEVEL_EN
   assign level_o = count;
`endif

endmodule
